fft_out_reorder: RTL and testbench

//  Output reorder buffer for the R2SDF pipeline. Consumes the bit-reversed sample stream leaving
//  the last SDF stage and re-emits each N-point frame in natural order (X[0]..X[N-1]).

---
 rtl/fft_out_reorder_pkg.sv | 16 +
 rtl/fft_out_reorder_if.sv | 31 +++
 rtl/fft_out_reorder_dpram.sv | 36 +++
 rtl/fft_out_reorder.sv | 129 ++++++++++++
 tb/tb_fft_out_reorder.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_out_reorder_pkg.sv
// Shared types and widths for the FFT output reorder buffer.
// The sample width comes from DATA_IN_WIDTH, which defaults to 16 when it is not defined elsewhere.
`ifndef DATA_IN_WIDTH
`define DATA_IN_WIDTH 16
`endif

package fft_out_reorder_pkg;

    localparam int DW = `DATA_IN_WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_t;

endpackage

// File: rtl/fft_out_reorder_if.sv
// Sample stream bus of the reorder buffer: bit-reversed input side and natural-order output side.
// do_idx/do_last and the LOG2_N parameter exist only when FFT_REORDER_IDX_EN is defined.
interface fft_out_reorder_if
`ifdef FFT_REORDER_IDX_EN
    #(parameter int LOG2_N = 6)
`endif
    ;
    import fft_out_reorder_pkg::*;

    logic          di_en;
    logic [DW-1:0] di_re;
    logic [DW-1:0] di_im;
    logic          do_en;
    logic [DW-1:0] do_re;
    logic [DW-1:0] do_im;
`ifdef FFT_REORDER_IDX_EN
    logic [LOG2_N-1:0] do_idx;
    logic              do_last;

    modport master (output di_en, di_re, di_im,
                    input  do_en, do_re, do_im, do_idx, do_last);
    modport slave  (input  di_en, di_re, di_im,
                    output do_en, do_re, do_im, do_idx, do_last);
`else
    modport master (output di_en, di_re, di_im,
                    input  do_en, do_re, do_im);
    modport slave  (input  di_en, di_re, di_im,
                    output do_en, do_re, do_im);
`endif

endinterface

// File: rtl/fft_out_reorder_dpram.sv
// Simple dual-port RAM: synchronous write, registered read with hold when not enabled.
// Storage has no reset; only the read data register is cleared.
module reorder_dpram #(
    parameter int AW = 4,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem_q [2**AW];
    logic [W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: writes bit-reversed frames in arrival order, reads them back in natural order.
// Defining FFT_REORDER_IDX_EN adds the do_idx/do_last outputs.
module fft_out_reorder
    import fft_out_reorder_pkg::*;
#(
    parameter int LOG2_N = 6
) (
    input  logic             clk,
    input  logic             rstn,
    fft_out_reorder_if.slave bus
);

    logic [LOG2_N-1:0] wcnt_q, wcnt_d;
    logic [LOG2_N-1:0] rcnt_q, rcnt_d;
    logic [LOG2_N-1:0] rd_ptr;
    logic              wbank_q, wbank_d;
    logic              rbank_q, rbank_d;
    logic [1:0]        full_q, full_d;
    rd_state_t         state_q, state_d;
    logic              issue_q;
    logic              wr_last;
    logic              rd_last;
    logic              rd_issue;
    logic [2*DW-1:0]   rd_data;

    // Natural bin k of a frame was written at position bitrev(k).
    for (genvar gi = 0; gi < LOG2_N; gi++) begin : g_bitrev
        assign rd_ptr[gi] = rcnt_q[LOG2_N-1-gi];
    end

    assign wr_last = bus.di_en && (wcnt_q == '1);
    assign rd_last = (rcnt_q == '1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            full_q  <= '0;
            issue_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            full_q  <= full_d;
            issue_q <= rd_issue;
        end
    end

    always_comb begin
        wcnt_d  = bus.di_en ? wcnt_q + 1'b1 : wcnt_q;
        wbank_d = wbank_q ^ wr_last;
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rbank_d = rbank_q;
        full_d  = full_q;
        case (state_q)
            ST_IDLE: begin
                if (full_q[rbank_q]) begin
                    state_d = ST_READ;
                    rcnt_d  = '0;
                end
            end
            ST_READ: begin
                rcnt_d = rcnt_q + 1'b1;
                if (rd_last) begin
                    full_d[rbank_q] = 1'b0;
                    rbank_d         = ~rbank_q;
                    // Continue straight into the other bank if it is, or is just becoming, full.
                    if (!(full_q[~rbank_q] || (wr_last && (wbank_q != rbank_q)))) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (wr_last) begin
            full_d[wbank_q] = 1'b1;
        end
    end

    always_comb begin
        rd_issue = (state_q == ST_READ);
    end

    // A write that lands while reset is held goes to address 0 and is overwritten by the first real sample.
    reorder_dpram #(
        .AW (LOG2_N + 1),
        .W  (2 * DW)
    ) u_ram (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en_i   (bus.di_en),
        .wr_addr_i ({wbank_q, wcnt_q}),
        .wr_data_i ({bus.di_re, bus.di_im}),
        .rd_en_i   (rd_issue),
        .rd_addr_i ({rbank_q, rd_ptr}),
        .rd_data_o (rd_data)
    );

    assign bus.do_en = issue_q;
    assign bus.do_re = rd_data[2*DW-1:DW];
    assign bus.do_im = rd_data[DW-1:0];

`ifdef FFT_REORDER_IDX_EN
    logic [LOG2_N-1:0] do_idx_q;
    logic              do_last_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            do_idx_q  <= '0;
            do_last_q <= 1'b0;
        end else begin
            if (rd_issue) begin
                do_idx_q <= rcnt_q;
            end
            do_last_q <= rd_issue && rd_last;
        end
    end

    assign bus.do_idx  = do_idx_q;
    assign bus.do_last = do_last_q;
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder (N=8) against a frame-level permutation model.
// Also checks do_idx/do_last when FFT_REORDER_IDX_EN is defined.
module tb_fft_out_reorder;
    import fft_out_reorder_pkg::*;

    localparam int LOG2_N = 3;
    localparam int N      = 1 << LOG2_N;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        int            idx;
    } smp_t;

    logic clk;
    logic rstn;

`ifdef FFT_REORDER_IDX_EN
    fft_out_reorder_if #(.LOG2_N(LOG2_N)) bus ();
`else
    fft_out_reorder_if bus ();
`endif

    fft_out_reorder #(.LOG2_N(LOG2_N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   run = 0;
    int   last_run = 0;
    smp_t frame_q[$];
    smp_t exp_q[$];
    int   lit[N];

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end else begin
            $display("ok   %s: %0h at %0t", name, act, $time);
        end
    endtask

    function automatic int brev(int k);
        int r = 0;
        for (int b = 0; b < LOG2_N; b++) r = r * 2 + ((k >> b) & 1);
        return r;
    endfunction

    // Model: once N samples have arrived, bin k of the frame is the sample that arrived at position bitrev(k).
    always @(posedge clk) begin
        if (!rstn) begin
            frame_q.delete();
        end else if (bus.di_en) begin
            smp_t s;
            s.re  = bus.di_re;
            s.im  = bus.di_im;
            s.idx = 0;
            frame_q.push_back(s);
            if (frame_q.size() == N) begin
                for (int k = 0; k < N; k++) begin
                    smp_t e;
                    e     = frame_q[brev(k)];
                    e.idx = k;
                    exp_q.push_back(e);
                end
                frame_q.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            run = 0;
            check("rst_do_en", {31'd0, bus.do_en}, 32'd0);
            check("rst_do_re", {16'd0, bus.do_re}, 32'd0);
            check("rst_do_im", {16'd0, bus.do_im}, 32'd0);
`ifdef FFT_REORDER_IDX_EN
            check("rst_do_idx", {29'd0, bus.do_idx}, 32'd0);
            check("rst_do_last", {31'd0, bus.do_last}, 32'd0);
`endif
        end else if (bus.do_en) begin
            run++;
            if (exp_q.size() == 0) begin
                check("unexpected_do_en", {31'd0, bus.do_en}, 32'd0);
            end else begin
                smp_t e;
                e = exp_q.pop_front();
                check("do_re", {16'd0, bus.do_re}, {16'd0, e.re});
                check("do_im", {16'd0, bus.do_im}, {16'd0, e.im});
`ifdef FFT_REORDER_IDX_EN
                check("do_idx", {29'd0, bus.do_idx}, 32'(e.idx));
                check("do_last", {31'd0, bus.do_last}, {31'd0, (e.idx == N - 1)});
`endif
            end
        end else begin
`ifdef FFT_REORDER_IDX_EN
            check("do_last_idle", {31'd0, bus.do_last}, 32'd0);
`endif
            if (run != 0) begin
                check("burst_len_mod_n", 32'(run % N), 32'd0);
                last_run = run;
                run      = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] v);
        bus.di_en = 1'b1;
        bus.di_re = v;
        bus.di_im = DW'(-v);
        tick();
        bus.di_en = 1'b0;
    endtask

    task automatic send_frame(input int base, input int gap);
        for (int i = 0; i < N; i++) begin
            send(DW'(base + i));
            if (gap != 0) tick();
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || bus.do_en) && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d samples still pending, required 0", exp_q.size());
        end
        repeat (2) tick();
    endtask

    task automatic lit_burst();
        int t = 0;
        while (!bus.do_en && t < 40) begin
            tick();
            t++;
        end
        if (t >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_do_en_timeout: do_en low for %0d cycles, required high", t);
        end
        for (int k = 0; k < N; k++) begin
            check("lit_do_en", {31'd0, bus.do_en}, 32'd1);
            check("lit_do_re", {16'd0, bus.do_re}, 32'(lit[k]));
            check("lit_do_im", {16'd0, bus.do_im}, {16'd0, DW'(-lit[k])});
            tick();
        end
        check("lit_burst_end", {31'd0, bus.do_en}, 32'd0);
    endtask

    initial begin
        lit[0] = 0; lit[1] = 4; lit[2] = 2; lit[3] = 6;
        lit[4] = 1; lit[5] = 5; lit[6] = 3; lit[7] = 7;
        rstn      = 1'b0;
        bus.di_en = 1'b0;
        bus.di_re = '0;
        bus.di_im = '0;

        // Reset held with input activity.
        tick();
        bus.di_en = 1'b1;
        bus.di_re = 16'h1234;
        bus.di_im = 16'h5678;
        repeat (3) tick();
        bus.di_en = 1'b0;
        rstn      = 1'b1;
        tick();

        // One contiguous frame with the exact latency.
        send_frame(0, 0);
        check("lat_edge1_do_en", {31'd0, bus.do_en}, 32'd0);
        tick();
        check("lat_edge1_do_en", {31'd0, bus.do_en}, 32'd0);
        tick();
        for (int k = 0; k < N; k++) begin
            check("t2_do_en", {31'd0, bus.do_en}, 32'd1);
            check("t2_do_re", {16'd0, bus.do_re}, 32'(lit[k]));
            check("t2_do_im", {16'd0, bus.do_im}, {16'd0, DW'(-lit[k])});
            tick();
        end
        check("t2_burst_end", {31'd0, bus.do_en}, 32'd0);
        check("t2_hold_re", {16'd0, bus.do_re}, 32'd7);
        drain();

        // Three back-to-back frames.
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) send(DW'($urandom));
        end
        drain();
        check("t3_burst_len", 32'(last_run), 32'(3 * N));

        // Gapped input, one frame.
        fork
            send_frame(0, 1);
            lit_burst();
        join
        drain();
        check("t4_burst_len", 32'(last_run), 32'(N));

        // Reset after 5 input samples.
        for (int i = 0; i < 5; i++) send(DW'($urandom));
        rstn = 1'b0;
        #1;
        check("t5a_do_en_drop", {31'd0, bus.do_en}, 32'd0);
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        fork
            send_frame(0, 0);
            lit_burst();
        join
        drain();

        // Reset during a read burst.
        send_frame(100, 0);
        repeat (5) tick();
        check("t5b_in_burst", {31'd0, bus.do_en}, 32'd1);
        rstn = 1'b0;
        #1;
        check("t5b_do_en_drop", {31'd0, bus.do_en}, 32'd0);
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        fork
            send_frame(0, 0);
            lit_burst();
        join
        drain();

        // Random data with random gaps across many frames.
        for (int i = 0; i < 6 * N; i++) begin
            while ($urandom_range(0, 9) < 3) tick();
            send(DW'($urandom));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
